round_controller: RTL and testbench

//   Game-round sequencer for Beat-The-Clock-Binary. Sits directly downstream of the 5-bit LFSR.

---
 rtl/round_controller.sv | 117 +++++++++++
 tb/tb_round_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// Round sequencer for Beat-The-Clock-Binary: latches an LFSR target, runs the
// per-round countdown, judges submits and tracks score and lives.
module round_controller #(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned TICK_DIV      = 100_000_000,
  parameter int unsigned ROUND_SECS    = 10,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned RESULT_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] random_number,
  input  logic             start,
  input  logic             submit,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] target,
  output logic [3:0]       time_left,
  output logic [7:0]       score,
  output logic [1:0]       lives_left,
  output logic [1:0]       state,
  output logic             round_win,
  output logic             round_lose,
  output logic             game_over
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RES_W  = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_RESULT = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t            st;
  logic [TICK_W-1:0] tick_cnt;
  logic [RES_W-1:0]  res_cnt;
  logic              tick_wrap_c;
  logic              hit_c;
  logic              timeout_c;

  assign state       = st;
  assign tick_wrap_c = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign hit_c       = submit && (switches == target);
  // A submit on the final tick edge pre-empts the timeout.
  assign timeout_c   = !submit && tick_wrap_c && (time_left == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      target     <= '0;
      time_left  <= 4'd0;
      score      <= 8'd0;
      lives_left <= 2'(LIVES);
      tick_cnt   <= '0;
      res_cnt    <= '0;
      round_win  <= 1'b0;
      round_lose <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      round_win  <= 1'b0;
      round_lose <= 1'b0;
      unique case (st)
        S_IDLE, S_OVER: begin
          if (start) begin
            score      <= 8'd0;
            lives_left <= 2'(LIVES);
            game_over  <= 1'b0;
            target     <= random_number;
            time_left  <= 4'(ROUND_SECS);
            tick_cnt   <= '0;
            st         <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (hit_c) begin
            if (score != 8'hFF) score <= score + 8'd1;
            round_win <= 1'b1;
            res_cnt   <= '0;
            st        <= S_RESULT;
          end else if (submit || timeout_c) begin
            if (timeout_c) time_left <= 4'd0;
            round_lose <= 1'b1;
            res_cnt    <= '0;
            if (lives_left <= 2'd1) begin
              lives_left <= 2'd0;
              game_over  <= 1'b1;
              st         <= S_OVER;
            end else begin
              lives_left <= lives_left - 2'd1;
              st         <= S_RESULT;
            end
          end else if (tick_wrap_c) begin
            tick_cnt <= '0;
            if (time_left != 4'd0) time_left <= time_left - 4'd1;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        S_RESULT: begin
          if (res_cnt == RES_W'(RESULT_CYCLES - 1)) begin
            res_cnt   <= '0;
            target    <= random_number;
            time_left <= 4'(ROUND_SECS);
            tick_cnt  <= '0;
            st        <= S_PLAY;
          end else begin
            res_cnt <= res_cnt + RES_W'(1);
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed plus randomized bench for round_controller, checked every cycle
// against a round/elapsed-time reference model.
module tb_round_controller;

  localparam int unsigned W  = 5;
  localparam int unsigned TD = 4;
  localparam int unsigned RS = 3;
  localparam int unsigned LV = 3;
  localparam int unsigned RC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] random_number;
  logic         start;
  logic         submit;
  logic [W-1:0] switches;
  logic [W-1:0] target;
  logic [3:0]   time_left;
  logic [7:0]   score;
  logic [1:0]   lives_left;
  logic [1:0]   state;
  logic         round_win;
  logic         round_lose;
  logic         game_over;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: game phase, cycles elapsed in the round, result dwell left.
  int m_st, m_target, m_time, m_score, m_lives, m_win, m_lose, m_go;
  int m_el, m_dwell;

  round_controller #(
    .WIDTH(W), .TICK_DIV(TD), .ROUND_SECS(RS), .LIVES(LV), .RESULT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .random_number(random_number), .start(start),
    .submit(submit), .switches(switches), .target(target), .time_left(time_left),
    .score(score), .lives_left(lives_left), .state(state), .round_win(round_win),
    .round_lose(round_lose), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic int shown_time();
    return (m_st == 1) ? int'(RS) - m_el / int'(TD) : m_time;
  endfunction

  function automatic void new_round();
    m_target = int'(random_number);
    m_el     = 0;
    m_st     = 1;
  endfunction

  function automatic void lose_life(input int t);
    m_time = t;
    m_lose = 1;
    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    if (m_lives == 0) begin
      m_go = 1;
      m_st = 3;
    end else begin
      m_st    = 2;
      m_dwell = RC;
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_st = 0; m_target = 0; m_time = 0; m_score = 0; m_lives = LV;
      m_win = 0; m_lose = 0; m_go = 0; m_el = 0; m_dwell = 0;
      return;
    end
    m_win = 0;
    m_lose = 0;
    if (m_st == 0 || m_st == 3) begin
      if (start) begin
        m_score = 0;
        m_lives = LV;
        m_go    = 0;
        new_round();
      end
    end else if (m_st == 1) begin
      if (submit) begin
        if (int'(switches) == m_target) begin
          m_time  = shown_time();
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_win   = 1;
          m_st    = 2;
          m_dwell = RC;
        end else begin
          lose_life(shown_time());
        end
      end else begin
        m_el++;
        if (m_el >= int'(RS * TD)) lose_life(0);
      end
    end else begin
      m_dwell--;
      if (m_dwell == 0) new_round();
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("target",     32'(target),     32'(m_target));
    check("time_left",  32'(time_left),  32'(shown_time()));
    check("score",      32'(score),      32'(m_score));
    check("lives_left", 32'(lives_left), 32'(m_lives));
    check("state",      32'(state),      32'(m_st));
    check("round_win",  32'(round_win),  32'(m_win));
    check("round_lose", 32'(round_lose), 32'(m_lose));
    check("game_over",  32'(game_over),  32'(m_go));
  endtask

  // One clock: DUT and model both consume the inputs currently driven.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; submit = 1'b0; switches = '0; random_number = '0;
    #2;
    step();
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_lives", 32'(lives_left), 32'd3);
    rst = 1'b0;

    // Start with a known target, then win the round.
    random_number = 5'b10101;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_target", 32'(target), 32'd21);
    check("start_time", 32'(time_left), 32'd3);
    switches = 5'd21;
    submit = 1'b1;
    step();
    submit = 1'b0;
    check("win_pulse", 32'(round_win), 32'd1);
    check("win_score", 32'(score), 32'd1);
    random_number = 5'(W'($urandom));
    step();
    random_number = 5'(W'($urandom));
    step();
    check("reload_state", 32'(state), 32'd1);

    // Three wrong submits exhaust the lives.
    for (int i = 0; i < 3; i++) begin
      switches = 5'(m_target) ^ 5'd1;
      submit = 1'b1;
      step();
      submit = 1'b0;
      if (m_st == 2) begin
        step();
        step();
      end
    end
    check("over_state", 32'(state), 32'd3);
    check("over_flag", 32'(game_over), 32'd1);
    switches = 5'(target);
    submit = 1'b1;
    step();
    submit = 1'b0;
    random_number = 5'(W'($urandom));
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_lives", 32'(lives_left), 32'd3);

    // Let the round time out.
    repeat (12) step();
    check("timeout_lose", 32'(round_lose), 32'd1);
    check("timeout_lives", 32'(lives_left), 32'd2);
    check("timeout_time", 32'(time_left), 32'd0);
    step();
    step();

    // Correct submit on the timeout edge.
    repeat (11) step();
    switches = 5'(m_target);
    submit = 1'b1;
    step();
    submit = 1'b0;
    check("edge_win", 32'(round_win), 32'd1);
    check("edge_nolose", 32'(round_lose), 32'd0);
    check("edge_lives", 32'(lives_left), 32'd2);

    // Randomized play.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom % 400) == 0;
      start         = ($urandom % 8) == 0;
      submit        = ($urandom % 6) == 0;
      switches      = ($urandom % 2 == 0) ? 5'(m_target) : 5'(W'($urandom));
      random_number = 5'(W'($urandom));
      step();
    end
    rst = 1'b0; start = 1'b0; submit = 1'b0;

    // Reset in the middle of a scored round.
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    switches = 5'(m_target);
    submit = 1'b1;
    step();
    submit = 1'b0;
    repeat (3) step();
    check("mid_score", 32'(score), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_score", 32'(score), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
